// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: digit count,
// dark-pin constants, scan FSM states and the displayed-value record.
package seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF    = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef enum logic [1:0] {
    OFF,
    BLANK,
    SHOW
  } scan_state_e;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        lz_en;
  } disp_t;

  // Selects BCD nibble idx from a packed 4-digit value.
  function automatic logic [3:0] bcd_field(input logic [15:0] value,
                                           input logic [1:0]  idx);
    return value[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/bcd_7seg.sv
// BCD to seven-segment decoder, active-low segments {g,f,e,d,c,b,a}.
// Non-decimal codes decode to an unlit digit.
module bcd_7seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode display scanner with per-slot blanking gap and
// frame-aligned (tear-free) value updates. All pin outputs are registered.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t       BLANK_LAST = cnt_t'(BLANK_CYC - 1);
  localparam cnt_t       SLOT_LAST  = cnt_t'(REFRESH_DIV - 1);
  localparam logic [1:0] IDX_LAST   = 2'(NUM_DIGITS - 1);

  scan_state_e state, state_nx;
  cnt_t        cnt, cnt_nx;
  logic [1:0]  idx, idx_nx;
  disp_t       shadow, active;
  logic        copy, wrap, tick_pend;

  logic [3:0]  digit_sel;
  logic [6:0]  dec_seg;
  logic        lz_blank;
  logic [3:0]  an_nx;
  logic [6:0]  seg_nx;
  logic        dp_nx;

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    copy     = 1'b0;
    wrap     = 1'b0;
    if (!en) begin
      state_nx = OFF;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        OFF: begin
          state_nx = BLANK;
          cnt_nx   = '0;
          idx_nx   = '0;
          copy     = 1'b1;
        end
        BLANK: begin
          cnt_nx = cnt + cnt_t'(1);
          if (cnt == BLANK_LAST) state_nx = SHOW;
        end
        SHOW: begin
          if (cnt == SLOT_LAST) begin
            cnt_nx   = '0;
            idx_nx   = idx + 2'd1;
            state_nx = BLANK;
            if (idx == IDX_LAST) begin
              copy = 1'b1;
              wrap = 1'b1;
            end
          end else begin
            cnt_nx = cnt + cnt_t'(1);
          end
        end
        default: state_nx = OFF;
      endcase
    end
  end

  assign digit_sel = bcd_field(active.digits, idx);

  bcd_7seg u_dec (
    .bcd (digit_sel),
    .seg (dec_seg)
  );

  // A digit is a leading zero when it and every more-significant digit are 0.
  assign lz_blank = active.lz_en && (idx != 2'd0) &&
                    ((active.digits >> {idx, 2'b00}) == 16'h0000);

  always_comb begin
    an_nx  = AN_OFF;
    seg_nx = SEG_OFF;
    dp_nx  = 1'b1;
    if (en && state == SHOW) begin
      an_nx  = ~(4'b0001 << idx);
      seg_nx = lz_blank ? SEG_OFF : dec_seg;
      dp_nx  = ~active.dp[idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what makes a same-edge load land in
  // shadow while active still takes the old shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= OFF;
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      active <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      if (load) shadow <= '{digits: digits, dp: dp_in, lz_en: lz_en};
      if (copy) active <= shadow;
    end
  end

  // tick_pend delays the wrap so frame_tick meets digit 0's first dark cycle on the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
      tick_pend  <= 1'b0;
    end else begin
      an         <= an_nx;
      seg        <= seg_nx;
      dp         <= dp_nx;
      tick_pend  <= wrap;
      frame_tick <= en & tick_pend;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position reference model pushes
// expected pin values each edge; a negedge monitor pops and compares.
module tb_seg_scan_ctrl;

  localparam int R     = 8;
  localparam int B     = 2;
  localparam int FRAME = 4 * R;
  localparam logic [12:0] DARK = {4'b1111, 7'b1111111, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .REFRESH_DIV (R),
    .BLANK_CYC   (B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .digits     (digits),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  p;
    logic        lz;
  } view_t;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  logic [12:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  view_t       shd = '0;
  view_t       act = '0;
  bit          running = 1'b0;
  int          k = 0;
  logic [15:0] rnd_d;

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s @%0t: got an=%b seg=%b dp=%b tick=%b, want an=%b seg=%b dp=%b tick=%b",
               name, $time, got[12:9], got[8:2], got[1], got[0],
               want[12:9], want[8:2], want[1], want[0]);
    end
  endtask

  // Pins {an,seg,dp} at position pos (0..FRAME-1) within a frame showing v.
  function automatic logic [11:0] view_pins(input int pos, input view_t v);
    int         slot = pos / R;
    int         w    = pos % R;
    logic [3:0] an_v = 4'b1111;
    logic [3:0] nib;
    logic [6:0] seg_v;
    bit         blank;
    if (w < B) return {4'b1111, 7'b1111111, 1'b1};
    an_v[slot] = 1'b0;
    nib   = v.d[slot*4 +: 4];
    blank = v.lz && (slot > 0);
    for (int j = slot; j < 4; j++)
      if (v.d[j*4 +: 4] != 4'h0) blank = 1'b0;
    if (blank || nib > 4'd9) seg_v = 7'b1111111;
    else                     seg_v = seg_tab[nib];
    return {an_v, seg_v, ~v.p[slot]};
  endfunction

  // k counts edges since the edge that saw en=1 in the dark state.
  task automatic model_edge();
    logic [12:0] e;
    int          pos;
    if (!en) begin
      e       = DARK;
      running = 1'b0;
    end else if (!running) begin
      e       = DARK;
      running = 1'b1;
      k       = 0;
      act     = shd;
    end else begin
      k++;
      pos = (k - 1) % FRAME;
      e   = {view_pins(pos, act), (pos == 0 && k > 1)};
      if (k % FRAME == 0) act = shd;
    end
    if (load) shd = {digits, dp_in, lz_en};
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      load = 1'b0;
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic lz);
    digits = d;
    dp_in  = p;
    lz_en  = lz;
    load   = 1'b1;
    cycles(1);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && exp_q.size() > 0)
      check("scan", {an, seg, dp, frame_tick}, exp_q.pop_front());
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check("reset_dark", {an, seg, dp, frame_tick}, DARK);
    #9 rst_n = 1'b1;

    // Decode, scan order, dp, and a load landing mid-frame.
    do_load(16'h1234, 4'b0100, 1'b0);
    en = 1'b1;
    cycles(12);
    do_load(16'h5678, 4'b0100, 1'b0);
    cycles(70);

    // Leading-zero blanking, then all-zero value.
    do_load(16'h0050, 4'b0000, 1'b1);
    cycles(70);
    do_load(16'h0000, 4'b0001, 1'b1);
    cycles(70);

    // Non-decimal digit, then disable mid-SHOW and re-enable.
    do_load(16'h00A0, 4'b0000, 1'b0);
    cycles(45);
    en = 1'b0;
    cycles(3);
    en = 1'b1;
    cycles(40);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    en = 1'b0;
    #1 check("async_reset_dark", {an, seg, dp, frame_tick}, DARK);
    repeat (2) @(posedge clk);
    #1 check("reset_held_dark", {an, seg, dp, frame_tick}, DARK);
    running = 1'b0;
    shd     = '0;
    act     = '0;
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    en = 1'b1;
    cycles(40);

    // Randomised loads and enable toggling.
    for (int i = 0; i < 2000; i++) begin
      if (en) begin
        if ($urandom_range(0, 149) == 0) en = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        en = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) begin
        for (int j = 0; j < 4; j++)
          rnd_d[j*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        digits = rnd_d;
        dp_in  = 4'($urandom);
        lz_en  = 1'($urandom);
        load   = 1'b1;
      end
      cycles(1);
    end

    en = 1'b0;
    cycles(2);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit common-anode seven-segment display on the board. It holds a 4-digit BCD value and steps through the digits in turn, driving one anode at a time. Each digit passes through the shared BCD-to-segment decoder. It inserts a blanking gap between digits to suppress ghosting and updates the displayed value only at frame boundaries, so digits never tear. It sits between user logic (counters, FSMs) and the display pins.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot (50 MHz -> 1 kHz per digit, 250 Hz frame); must be >= 4
BLANK_CYC, 1000, cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYC < REFRESH_DIV

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; 0 = display dark
load  in  1  capture strobe for digits/dp_in/lz_en into the shadow register
digits  in  16  BCD digits; [3:0] = digit0 (rightmost) ... [15:12] = digit3
dp_in  in  4  decimal point per digit, active high; bit i = digit i
lz_en  in  1  leading-zero blanking enable
an  out  4  anode drive, active low; an[i] selects digit i
seg  out  7  segments {g,f,e,d,c,b,a}, active low
dp  out  1  decimal point, active low
frame_tick  out  1  1-cycle pulse at the end of digit 3's slot

Behaviour:
- Reset (async, rst_n=0): an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0, state=OFF, slot counter=0, digit index=0, shadow=0, active=0.
- Registers: shadow {digits, dp_in, lz_en} and active copy of the same fields.
- load=1 at a rising edge writes shadow. Shadow is copied to active only on entry to digit 0's slot, which is the frame boundary. A load and a frame boundary on the same edge: active takes the old shadow, and the new value appears next frame.
- FSM states: OFF, BLANK, SHOW.
  - OFF: outputs dark. If en=1, go to BLANK with index=0 and counter=0, and copy shadow to active.
  - BLANK: an=1111, seg=7F, dp=1. Counter increments. At counter==BLANK_CYC-1, go to SHOW.
  - SHOW: drive digit[index]. At counter==REFRESH_DIV-1, counter resets to 0, index=(index+1) mod 4, go to BLANK. On wrap 3->0, copy shadow to active and pulse frame_tick.
  - Any state: en=0 at a rising edge -> OFF next cycle. Counter and index clear. Outputs dark on that same registered update.
- Digit order: 0,1,2,3,0... Each slot is exactly REFRESH_DIV cycles (BLANK_CYC blank + REFRESH_DIV-BLANK_CYC show). A frame is 4*REFRESH_DIV cycles.
- SHOW outputs:
  - an = ~(4'b0001 << index).
  - seg = decoder(active digit[index]). BCD values 10..15 decode to 7F (dark digit, anode still asserted).
  - dp = ~active.dp_in[index].
- Leading-zero blanking: when active.lz_en=1 and index>0 and all active digits index..3 are 0, seg=7F for that slot. dp is still driven from dp_in. Digit 0 is never blanked.
- an, seg, dp and frame_tick are registered. Pins reflect a state change one cycle after it. frame_tick is high for exactly one cycle, aligned with the first BLANK cycle of digit 0 on the pins.
- Counter width is $clog2(REFRESH_DIV). No wrap beyond REFRESH_DIV-1.
- Reset mid-slot: outputs go dark immediately (asynchronous). After release the block restarts from OFF.

Decomposition:
- Shared package seg_pkg:
  - NUM_DIGITS=4, SEG_OFF=7'b1111111, AN_OFF=4'b1111
  - scan state enum {OFF, BLANK, SHOW}
  - BCD field slice helper.
- One sub-module: instance of the existing bcd_7seg decoder (4-bit BCD in, 7-bit active-low segments out). It is fed by the index mux; its output is gated by blanking and then registered.

Test Plan:
- Bench parameters: REFRESH_DIV=8, BLANK_CYC=2.
- Reset and enable: rst_n=0, en=0 -> an=1111, seg=7F, dp=1. Release reset and raise en -> 2 cycles dark, then an=1110 for 6 cycles, then 2 dark, then an=1101 for 6 cycles.
- Decode and scan: load digits=16'h1234, dp_in=4'b0100, en=1 -> seg per slot: digit0=0011001 ("4"), digit1=0110000 ("3"), digit2=0100100 ("2") with dp=0, digit3=1111001 ("1"). Sequence repeats every 32 cycles. frame_tick pulses once per 32 cycles.
- Tear-free update: during digit1's slot, load digits=16'h5678 -> digits 2 and 3 of the current frame still show "2","1". The next frame shows 8,7,6,5.
- Leading zeros: digits=16'h0050, lz_en=1 -> digit3 and digit2 seg=7F (anodes still cycle). digit1="5" (0010010), digit0="0" (1000000). digits=16'h0000 -> only digit0 shows "0".
- Invalid BCD and disable: digits=16'h00A0, lz_en=0 -> digit1 seg=7F, others "0". Deassert en mid-SHOW -> next cycle an=1111, seg=7F, dp=1. Re-enable -> restarts at digit0 after a 2-cycle blank.
- Async reset mid-slot: pull rst_n low between clock edges -> outputs dark immediately, no clock needed. The shadow register reads 0 after release.
